// File: rtl/seq_div_pkg.sv
// Shared types and default widths for the seq_div iterative divider.
//   state_t : control states of the divider FSM (IDLE, RUN, DONE)
//   N_DEF   : default dividend / quotient width
//   M_DEF   : default divisor / remainder width
package seq_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int N_DEF = 4;
    localparam int M_DEF = 2;

endpackage

// File: rtl/seq_div_if.sv
// Operand / result handshake bundle for seq_div.
//   in_valid, in_ready       : operand handshake
//   dividend[N], divisor[M]  : unsigned operands
//   out_valid, out_ready     : result handshake
//   quotient[N], remainder[M]: unsigned results
//   div_err                  : divide-by-zero flag (only with SEQ_DIV_ZERO_ERR_EN)
// master = operand producer / result consumer, slave = the divider.
interface seq_div_if
    import seq_div_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int M = M_DEF
) ();

    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] dividend;
    logic [M-1:0] divisor;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] quotient;
    logic [M-1:0] remainder;
`ifdef SEQ_DIV_ZERO_ERR_EN
    logic         div_err;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_err
    );
    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_err
    );
`else
    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder
    );
    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder
    );
`endif

endinterface

// File: rtl/seq_div_step.sv
// div_step: one combinational restoring-division step.
//   rem_in[M]  : current partial remainder (always < divisor for nonzero divisor)
//   next_bit   : next dividend bit, MSB first
//   divisor[M] : divisor
//   rem_out[M] : partial remainder after the step
//   q_bit      : quotient bit produced by the step
// The trial value is M+1 bits wide so the compare and subtract cannot overflow.
module div_step #(
    parameter int M = 2
) (
    input  logic [M-1:0] rem_in,
    input  logic         next_bit,
    input  logic [M-1:0] divisor,
    output logic [M-1:0] rem_out,
    output logic         q_bit
);

    logic [M:0] trial;

    always_comb begin
        trial   = {rem_in, next_bit};
        q_bit   = (trial >= {1'b0, divisor});
        // Subtraction only taken when trial >= divisor, so the result fits in M bits.
        rem_out = q_bit ? M'(trial - {1'b0, divisor}) : trial[M-1:0];
    end

endmodule

// File: rtl/seq_div.sv
// seq_div: iterative restoring divider, one quotient bit per clock.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : seq_div_if.slave (operand and result handshakes)
// Accepts dividend/divisor in IDLE, runs N restoring steps in RUN, then holds
// quotient/remainder in DONE until out_ready. The dividend shift register is
// reused for the quotient: each step shifts the dividend MSB out and the new
// quotient bit in at the LSB.
// Optional macro SEQ_DIV_ZERO_ERR_EN: divisor 0 bypasses the iterations after
// one RUN cycle and reports div_err while the result is presented.
module seq_div
    import seq_div_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int M = M_DEF
) (
    input logic      clk,
    input logic      rst_n,
    seq_div_if.slave bus
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    state_t        state, state_nxt;
    logic [N-1:0]  sreg;
    logic [M-1:0]  rem;
    logic [M-1:0]  dvsr;
    logic [CW-1:0] cnt;
    logic [M-1:0]  rem_step;
    logic          q_bit;
    logic          last;
    logic          rdy;
    logic          vld;
`ifdef SEQ_DIV_ZERO_ERR_EN
    logic          zero_q;
    logic          err_q;
`endif

    div_step #(.M(M)) u_step (
        .rem_in   (rem),
        .next_bit (sreg[N-1]),
        .divisor  (dvsr),
        .rem_out  (rem_step),
        .q_bit    (q_bit)
    );

    assign last = (cnt == CW'(N - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        rdy       = 1'b0;
        vld       = 1'b0;
        case (state)
            IDLE: begin
                rdy = 1'b1;
                if (bus.in_valid) state_nxt = RUN;
            end
            RUN: begin
`ifdef SEQ_DIV_ZERO_ERR_EN
                if (zero_q || last) state_nxt = DONE;
`else
                if (last) state_nxt = DONE;
`endif
            end
            DONE: begin
                vld = 1'b1;
                if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg <= '0;
            rem  <= '0;
            dvsr <= '0;
            cnt  <= '0;
`ifdef SEQ_DIV_ZERO_ERR_EN
            zero_q <= 1'b0;
            err_q  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        sreg <= bus.dividend;
                        dvsr <= bus.divisor;
                        rem  <= '0;
                        cnt  <= '0;
`ifdef SEQ_DIV_ZERO_ERR_EN
                        zero_q <= (bus.divisor == '0);
`endif
                    end
                end
                RUN: begin
`ifdef SEQ_DIV_ZERO_ERR_EN
                    if (zero_q) begin
                        // sreg still holds the untouched dividend here.
                        rem   <= sreg[M-1:0];
                        sreg  <= '1;
                        err_q <= 1'b1;
                    end else begin
                        rem  <= rem_step;
                        sreg <= (sreg << 1) | N'(q_bit);
                        if (!last) cnt <= cnt + CW'(1);
                    end
`else
                    rem  <= rem_step;
                    sreg <= (sreg << 1) | N'(q_bit);
                    if (!last) cnt <= cnt + CW'(1);
`endif
                end
                DONE: begin
`ifdef SEQ_DIV_ZERO_ERR_EN
                    if (bus.out_ready) err_q <= 1'b0;
`endif
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = rdy;
    assign bus.out_valid = vld;
    assign bus.quotient  = sreg;
    assign bus.remainder = rem;
`ifdef SEQ_DIV_ZERO_ERR_EN
    assign bus.div_err   = err_q;
`endif

endmodule

// File: tb/tb_seq_div.sv
// Testbench for seq_div (N=4, M=2): directed cases with literal expectations,
// an exhaustive nonzero sweep and randomized operations, all checked against
// an arithmetic reference model by a per-cycle compare process.
module tb_seq_div;

    localparam int N = 4;
    localparam int M = 2;

    logic clk;
    logic rst_n;

    seq_div_if #(.N(N), .M(M)) bus ();

    seq_div #(.N(N), .M(M)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int exp_lat(input int b);
`ifdef SEQ_DIV_ZERO_ERR_EN
        return (b == 0) ? 2 : N + 1;
`else
        if (b < 0) return 0;
        return N + 1;
`endif
    endfunction

    // ---------------- reference model ----------------
    int cycnt = 0;
    always @(posedge clk) cycnt <= cycnt + 1;

    logic m_busy = 1'b0;
    int   m_age  = 0;
    int   m_lat  = 0;
    int   m_q    = 0;
    int   m_r    = 0;
    int   m_err  = 0;
    int   acc_cyc[$];
    int   res_q[$];
    int   res_r[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_age  <= 0;
        end else if (m_busy) begin
            if (m_age + 1 >= m_lat) begin
                if (bus.out_ready) begin
                    m_busy <= 1'b0;
                    res_q.push_back(int'(bus.quotient));
                    res_r.push_back(int'(bus.remainder));
                end
            end else begin
                m_age <= m_age + 1;
            end
        end else if (bus.in_valid) begin
            m_busy <= 1'b1;
            m_age  <= 0;
            m_lat  <= exp_lat(int'(bus.divisor));
            if (bus.divisor != 0) begin
                m_q   <= int'(bus.dividend) / int'(bus.divisor);
                m_r   <= int'(bus.dividend) % int'(bus.divisor);
                m_err <= 0;
            end else begin
                m_q   <= (1 << N) - 1;
                m_r   <= int'(bus.dividend) % (1 << M);
                m_err <= 1;
            end
            acc_cyc.push_back(cycnt);
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            logic exp_ov;
            exp_ov = m_busy && (m_age + 1 >= m_lat);
            chk("in_ready", bus.in_ready, !m_busy);
            chk("out_valid", bus.out_valid, exp_ov);
            if (exp_ov) begin
                chk("quotient", bus.quotient, m_q);
                chk("remainder", bus.remainder, m_r);
`ifdef SEQ_DIV_ZERO_ERR_EN
                chk("div_err", bus.div_err, m_err);
`endif
            end
        end
    end

    // ---------------- directed operation helper ----------------
    task automatic do_op(input int a, input int b, input int hold, output int q, output int r);
        int   cyc;
        logic seen;
        logic [N-1:0] hq;
        logic [M-1:0] hr;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.dividend = N'(a);
        bus.divisor  = M'(b);
        seen = 1'b0;
        for (int k = 0; k < 50; k++) begin
            if (bus.in_ready) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("accept_timeout", seen, 1'b1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.dividend = N'($urandom);
        bus.divisor  = M'($urandom);
        cyc  = 0;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            cyc++;
            if (bus.out_valid) begin
                seen = 1'b1;
                break;
            end
            chk("in_ready_busy", bus.in_ready, 1'b0);
        end
        chk("result_timeout", seen, 1'b1);
        chk("latency", cyc, exp_lat(b));
`ifdef SEQ_DIV_ZERO_ERR_EN
        chk("div_err_flag", bus.div_err, (b == 0));
`endif
        q  = int'(bus.quotient);
        r  = int'(bus.remainder);
        hq = bus.quotient;
        hr = bus.remainder;
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            chk("hold_valid", bus.out_valid, 1'b1);
            chk("hold_q", bus.quotient, hq);
            chk("hold_r", bus.remainder, hr);
            chk("hold_ready", bus.in_ready, 1'b0);
            bus.in_valid = 1'($urandom);
            bus.dividend = N'($urandom);
            bus.divisor  = M'($urandom);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int q, r, n0, nr, t0;
        logic ok;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_quotient", bus.quotient, 0);
        chk("rst_remainder", bus.remainder, 0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", bus.in_ready, 1'b1);

        do_op(13, 3, 0, q, r);
        chk("13/3 q", q, 4);
        chk("13/3 r", r, 1);
        do_op(15, 1, 0, q, r);
        chk("15/1 q", q, 15);
        chk("15/1 r", r, 0);
        do_op(2, 3, 0, q, r);
        chk("2/3 q", q, 0);
        chk("2/3 r", r, 2);

        for (int a = 0; a < 16; a++) begin
            for (int b = 1; b < 4; b++) begin
                do_op(a, b, 0, q, r);
                chk("sweep q", q, a / b);
                chk("sweep r", r, a % b);
            end
        end

        // Backpressure with ignored in_valid pulses during the hold.
        do_op(11, 2, 10, q, r);
        chk("11/2 q", q, 5);
        chk("11/2 r", r, 1);

        // Divide by zero.
        do_op(9, 0, 0, q, r);
        chk("9/0 q", q, 15);
        chk("9/0 r", r, 1);

        // Asynchronous reset in the middle of RUN.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.dividend = 4'd9;
        bus.divisor  = 2'd2;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst out_valid", bus.out_valid, 1'b0);
        chk("midrst quotient", bus.quotient, 0);
        chk("midrst remainder", bus.remainder, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("midrst in_ready", bus.in_ready, 1'b1);
        do_op(9, 2, 0, q, r);
        chk("9/2 q", q, 4);
        chk("9/2 r", r, 1);

        // Back-to-back with out_ready tied high.
        n0 = acc_cyc.size();
        nr = res_q.size();
        @(negedge clk);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.dividend  = 4'd6;
        bus.divisor   = 2'd2;
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (acc_cyc.size() > n0) begin
                ok = 1'b1;
                break;
            end
        end
        chk("b2b first accept", ok, 1'b1);
        bus.dividend = 4'd7;
        bus.divisor  = 2'd3;
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (acc_cyc.size() > n0 + 1) begin
                ok = 1'b1;
                break;
            end
        end
        chk("b2b second accept", ok, 1'b1);
        bus.in_valid = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (res_q.size() > nr + 1) begin
                ok = 1'b1;
                break;
            end
        end
        chk("b2b results", ok, 1'b1);
        bus.out_ready = 1'b0;
        if (ok) begin
            t0 = acc_cyc[n0];
            chk("b2b spacing", acc_cyc[n0 + 1] - t0, N + 2);
            chk("b2b q0", res_q[nr], 3);
            chk("b2b r0", res_r[nr], 0);
            chk("b2b q1", res_q[nr + 1], 2);
            chk("b2b r1", res_r[nr + 1], 1);
        end

        // Randomized operations with random backpressure and gaps.
        for (int i = 0; i < 120; i++) begin
            int a, b;
            a = int'($urandom_range(0, 15));
            b = int'($urandom_range(0, 3));
            do_op(a, b, int'($urandom_range(0, 3)), q, r);
            if (b != 0) begin
                chk("rand q", q, a / b);
                chk("rand r", r, a % b);
            end else begin
                chk("rand q0", q, 15);
                chk("rand r0", r, a % 4);
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
